// File: rtl/mem_arb_pkg.sv
// Shared types and funct3 codes for the memory port arbiter.
// MEM_ARB_MISALIGN_TRAP_EN enables misaligned-access trapping in mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS_RD,
        OWN_LS_WR,
        OWN_LS_TRAP
    } owner_t;

    localparam logic [2:0] F3_LB    = 3'b000;
    localparam logic [2:0] F3_LH    = 3'b001;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;
    localparam logic [2:0] F3_SB    = 3'b000;
    localparam logic [2:0] F3_SH    = 3'b001;
    localparam logic [2:0] F3_SW    = 3'b010;
    localparam logic [2:0] F3_FETCH = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_align_check.sv
// Flags halfword accesses on odd bytes and word accesses off a word boundary.
// Only instantiated when MEM_ARB_MISALIGN_TRAP_EN is defined.
module mem_align_check (
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    output logic       misaligned
);

    // funct3[1:0] gives the access width for both loads and stores
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto a single 1-cycle-latency memory port.
// Define MEM_ARB_MISALIGN_TRAP_EN to trap misaligned load/store and align fetches.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LS_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_misaligned,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    owner_t      r_owner;
    logic [2:0]  r_streak;
    logic [31:0] r_rd_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_force_if;
    logic        w_ls_gnt;
    logic        w_if_gnt;
    logic        w_ls_mis;
    logic [31:0] w_if_addr;
    logic        w_ls_rd;
    logic        w_ls_wr;
    logic        w_ls_trap;
    owner_t      w_next;

    assign w_force_if = (r_streak == 3'(LS_STREAK_MAX)) && if_req_valid && ls_req_valid;
    assign w_ls_gnt   = !reset && ls_req_valid && !w_force_if;
    assign w_if_gnt   = !reset && if_req_valid && !w_ls_gnt;

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    mem_align_check u_align (
        .funct3     (ls_funct3),
        .addr       (ls_addr[1:0]),
        .misaligned (w_ls_mis)
    );
    assign w_if_addr     = if_addr & ~32'd3;
    assign ls_misaligned = (r_owner == OWN_LS_TRAP);
`else
    assign w_ls_mis      = 1'b0;
    assign w_if_addr     = if_addr;
    assign ls_misaligned = 1'b0;
`endif

    assign w_ls_rd   = w_ls_gnt && !ls_we && !w_ls_mis;
    assign w_ls_wr   = w_ls_gnt &&  ls_we && !w_ls_mis;
    assign w_ls_trap = w_ls_gnt &&  w_ls_mis;

    assign if_req_ready = w_if_gnt;
    assign ls_req_ready = w_ls_gnt;

    // Memory samples these at the grant edge, so they are driven straight from the grant
    assign mem_write         = w_ls_wr;
    assign mem_funct3        = (w_ls_rd || w_ls_wr) ? ls_funct3 : F3_FETCH;
    assign mem_read_address  = w_if_gnt ? w_if_addr : (w_ls_rd ? ls_addr : r_rd_addr);
    assign mem_write_address = w_ls_wr ? ls_addr  : r_wr_addr;
    assign mem_write_data    = w_ls_wr ? ls_wdata : r_wr_data;

    always_comb begin
        w_next = OWN_NONE;
        if (w_if_gnt)       w_next = OWN_IF;
        else if (w_ls_rd)   w_next = OWN_LS_RD;
        else if (w_ls_wr)   w_next = OWN_LS_WR;
        else if (w_ls_trap) w_next = OWN_LS_TRAP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner   <= OWN_NONE;
            r_streak  <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_owner   <= w_next;
            r_rd_addr <= mem_read_address;
            r_wr_addr <= mem_write_address;
            r_wr_data <= mem_write_data;
            if (w_ls_gnt && if_req_valid) r_streak <= r_streak + 3'd1;
            else                          r_streak <= '0;
        end
    end

    assign if_rsp_valid = (r_owner == OWN_IF);
    assign if_rsp_data  = if_rsp_valid ? mem_read_data : '0;
    assign ls_rsp_valid = (r_owner == OWN_LS_RD) || (r_owner == OWN_LS_WR) ||
                          (r_owner == OWN_LS_TRAP);
    assign ls_rsp_data  = (r_owner == OWN_LS_RD) ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 8 kB memory and a response scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned STREAK = 4;

    logic        clk;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid, ls_misaligned;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        ifv;
        logic        lsv;
        logic        mis;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];

    mem_port_arbiter #(.LS_STREAK_MAX(STREAK)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_misaligned(ls_misaligned),
        .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (f3[1:0])
            2'b00: r[{a, 3'b000} +: 8] = d[7:0];
            2'b01: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic misal(input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        return (f3[1:0] == 2'b01) ? a[0] : ((f3[1:0] == 2'b10) ? (a != 2'b00) : 1'b0);
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural model of the downstream memory: synchronous write, registered read
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
        end else if (mem_write) begin
            mem[mem_write_address[12:2]] <= merge(mem[mem_write_address[12:2]],
                                                  mem_write_address[1:0], mem_funct3,
                                                  mem_write_data);
        end
        mem_read_data <= extract(mem[mem_read_address[12:2]], mem_read_address[1:0], mem_funct3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] ia,
                        input logic lv, input logic we, input logic [2:0] f3,
                        input logic [31:0] la, input logic [31:0] wd,
                        input logic exp_if, input logic exp_ls);
        exp_t        e;
        logic        mis;
        logic [31:0] fa;
        if_req_valid = iv;
        if_addr      = ia;
        ls_req_valid = lv;
        ls_we        = we;
        ls_funct3    = f3;
        ls_addr      = la;
        ls_wdata     = wd;
        @(negedge clk);
        check("if_req_ready", 32'(if_req_ready), 32'(exp_if));
        check("ls_req_ready", 32'(ls_req_ready), 32'(exp_ls));
        e   = '0;
        mis = misal(f3, la[1:0]);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        fa = ia & ~32'd3;
`else
        fa = ia;
`endif
        if (exp_ls) begin
            e.lsv = 1'b1;
            if (mis) begin
                e.mis = 1'b1;
                check("trap_mem_write", 32'(mem_write), 32'd0);
            end else if (we) begin
                check("st_mem_write", 32'(mem_write), 32'd1);
                check("st_funct3", 32'(mem_funct3), 32'(f3));
                check("st_waddr", mem_write_address, la);
                check("st_wdata", mem_write_data, wd);
                ref_mem[la[12:2]] = merge(ref_mem[la[12:2]], la[1:0], f3, wd);
            end else begin
                check("ld_mem_write", 32'(mem_write), 32'd0);
                check("ld_funct3", 32'(mem_funct3), 32'(f3));
                check("ld_raddr", mem_read_address, la);
                e.d = extract(ref_mem[la[12:2]], la[1:0], f3);
            end
        end else if (exp_if) begin
            e.ifv = 1'b1;
            check("if_mem_write", 32'(mem_write), 32'd0);
            check("if_funct3", 32'(mem_funct3), 32'(F3_FETCH));
            check("if_raddr", mem_read_address, fa);
            e.d = ref_mem[fa[12:2]];
        end else begin
            check("idle_mem_write", 32'(mem_write), 32'd0);
            check("idle_funct3", 32'(mem_funct3), 32'(F3_FETCH));
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("if_rsp_valid", 32'(if_rsp_valid), 32'(e.ifv));
        check("if_rsp_data", if_rsp_data, e.ifv ? e.d : 32'd0);
        check("ls_rsp_valid", 32'(ls_rsp_valid), 32'(e.lsv));
        check("ls_rsp_data", ls_rsp_data, e.lsv ? e.d : 32'd0);
        check("ls_misaligned", 32'(ls_misaligned), 32'(e.mis));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, F3_LW, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
        check({tag, "_ls_rsp_valid"}, 32'(ls_rsp_valid), 32'd0);
        check({tag, "_ls_misaligned"}, 32'(ls_misaligned), 32'd0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_funct3"}, 32'(mem_funct3), 32'(F3_FETCH));
        check({tag, "_mem_raddr"}, mem_read_address, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
        reset        = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        if_addr      = 32'h40;
        ls_we        = 1'b0;
        ls_funct3    = F3_LW;
        ls_addr      = 32'h80;
        ls_wdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_ready", 32'(if_req_ready), 32'd0);
        check("rst_ls_ready", 32'(ls_req_ready), 32'd0);
        check_reset_outputs("rst");
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        reset        = 1'b0;

        // Fetch-only burst: responses on consecutive cycles
        step(1'b1, 32'h0, 1'b0, 1'b0, F3_LW, '0, '0, 1'b1, 1'b0);
        check("fetch0_word", if_rsp_data, 32'hA000_0000);
        step(1'b1, 32'h4, 1'b0, 1'b0, F3_LW, '0, '0, 1'b1, 1'b0);
        check("fetch1_word", if_rsp_data, 32'hA000_0001);
        step(1'b1, 32'h8, 1'b0, 1'b0, F3_LW, '0, '0, 1'b1, 1'b0);
        check("fetch2_word", if_rsp_data, 32'hA000_0002);
        idle();

        // Both ports busy: LS x STREAK then one fetch, repeating
        for (int k = 0; k < 10; k++)
            step(1'b1, 32'h10, 1'b1, 1'b0, F3_LW, 32'h200 + 32'(4 * k), '0,
                 (k % 5) == 4, (k % 5) != 4);
        idle();

        // Byte store then signed and unsigned byte reloads
        step(1'b0, '0, 1'b1, 1'b1, F3_SB, 32'h103, 32'h0000_00A5, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, F3_LBU, 32'h103, '0, 1'b0, 1'b1);
        check("lbu_a5", ls_rsp_data, 32'h0000_00A5);
        step(1'b0, '0, 1'b1, 1'b0, F3_LB, 32'h103, '0, 1'b0, 1'b1);
        check("lb_a5", ls_rsp_data, 32'hFFFF_FFA5);

        // Store immediately followed by load of the same word
        step(1'b0, '0, 1'b1, 1'b1, F3_SH, 32'h100, 32'h0000_1234, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, F3_LW, 32'h100, '0, 1'b0, 1'b1);
        check("st_ld_same_word", ls_rsp_data, 32'hA500_1234);

        // Misaligned word load
        step(1'b0, '0, 1'b1, 1'b0, F3_LW, 32'h102, '0, 1'b0, 1'b1);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        check("lw_mis_flag", 32'(ls_misaligned), 32'd1);
        check("lw_mis_data", ls_rsp_data, 32'd0);
`else
        check("lw_unaligned_word", ls_rsp_data, 32'hA500_1234);
`endif
        step(1'b1, 32'h6, 1'b0, 1'b0, F3_LW, '0, '0, 1'b1, 1'b0);
        idle();

        // Reset while a fetch response is due
        if_req_valid = 1'b1;
        if_addr      = 32'h20;
        @(negedge clk);
        check("pre_rst_if_ready", 32'(if_req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        if_req_valid = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
        #1;
        check("inflight_dropped", 32'(if_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle();
            check("post_rst_raddr", mem_read_address, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's instruction-fetch port and load/store port onto the single read/write port pair of the 8 kB RV32I `memory` block. It sits directly upstream of that block and drives its `write_mem`, `funct3`, address and data inputs. It tracks which requester owns the one-cycle-latency read in flight and routes `read_data` back to that requester. Optionally, it traps misaligned accesses before they reach memory.

## Interface
Parameters:
- `LS_STREAK_MAX`, default 4: consecutive load/store grants allowed while fetch waits. After this many, fetch is forced one grant.

Ports:
- `clk` input 1: system clock (12 MHz).
- `reset` input 1: asynchronous, active-high reset.
- `if_req_valid` input 1: fetch request.
- `if_req_ready` output 1: fetch request accepted this cycle.
- `if_addr` input 32: fetch address.
- `if_rsp_valid` output 1: fetch data valid, one-cycle pulse.
- `if_rsp_data` output 32: instruction word.
- `ls_req_valid` input 1: load/store request.
- `ls_req_ready` output 1: load/store request accepted this cycle.
- `ls_we` input 1: 1 = store, 0 = load.
- `ls_funct3` input 3: RV32I width/sign code.
- `ls_addr` input 32: data address.
- `ls_wdata` input 32: store data.
- `ls_rsp_valid` output 1: load data or store ack, one-cycle pulse.
- `ls_rsp_data` output 32: load result (0 for stores).
- `ls_misaligned` output 1: qualifies `ls_rsp_valid`; access was trapped.
- `mem_write` output 1: to memory `write_mem`.
- `mem_funct3` output 3: to memory `funct3`.
- `mem_write_address` output 32: to memory.
- `mem_write_data` output 32: to memory.
- `mem_read_address` output 32: to memory.
- `mem_read_data` input 32: from memory `read_data`.

## Operation
- Exactly one request is granted per cycle. `funct3` is shared between the memory's read and write paths, so a read and a write never issue together.
- Priority is load/store over fetch, subject to the streak rule:
  - A 3-bit streak counter increments on each LS grant made while `if_req_valid` is high.
  - It clears on any fetch grant, or on any cycle where fetch is not requesting.
  - When the counter equals `LS_STREAK_MAX` and both ports request, fetch wins.
- Fetch grant drives:
  - `mem_read_address = if_addr`
  - `mem_funct3 = 3'b010`
  - `mem_write = 0`
- LS load grant drives:
  - `mem_read_address = ls_addr`
  - `mem_funct3 = ls_funct3`
  - `mem_write = 0`
- LS store grant drives:
  - `mem_write = 1`
  - `mem_write_address = ls_addr`
  - `mem_write_data = ls_wdata`
  - `mem_funct3 = ls_funct3`
  - `mem_read_address` holds its previous value.
- With no grant: `mem_write = 0`, `mem_funct3 = 3'b010`, and the addresses hold their previous values.
- Owner FSM, encoding the response due next cycle:
  - States: `OWN_NONE`, `OWN_IF`, `OWN_LS_RD`, `OWN_LS_WR`, `OWN_LS_TRAP`.
  - On every clock, next state is the type of this cycle's grant, or `OWN_NONE` if there was none.
- Response behaviour by owner state:
  - `OWN_IF`: `if_rsp_valid = 1`, `if_rsp_data = mem_read_data`.
  - `OWN_LS_RD`: `ls_rsp_valid = 1`, `ls_rsp_data = mem_read_data`.
  - `OWN_LS_WR`: `ls_rsp_valid = 1`, `ls_rsp_data = 0`.
  - `OWN_LS_TRAP`: `ls_rsp_valid = 1`, `ls_misaligned = 1`, `ls_rsp_data = 0`.
- A new grant in the same cycle a response is delivered is legal, giving full back-to-back throughput.

## Timing
- `*_req_ready` is combinational from the valids and the streak counter. It is 0 while `reset` is high.
- Latency: a request accepted at edge N has its response valid in the cycle after edge N, i.e. before edge N+1. Latency is exactly 1 and is never stalled.
- There is no response backpressure. The requester must sample on the pulse.
- `*_rsp_data` is meaningful only while the matching `*_rsp_valid` is high. Outside the pulse it is driven 0.
- Reset values: owner = `OWN_NONE`, streak = 0, all `rsp_valid` = 0, `mem_write` = 0, `mem_funct3` = `3'b010`, `mem_read_address` = 0, `ls_misaligned` = 0.
- Reset asserted with a read in flight: the response is dropped and no `rsp_valid` is produced after reset is released.
- A store followed immediately by a load to the same word returns the new data. The memory's write and read occur at the same edge, so the bench must check that ordering holds.

## Configuration
- `MEM_ARB_MISALIGN_TRAP_EN` defined:
  - Misaligned cases are: LS halfword with `ls_addr[0] = 1`; LS word with `ls_addr[1:0] != 0`; fetch with `if_addr[1:0] != 0`.
  - A misaligned LS access is accepted but not issued: `mem_write = 0` and the memory is not read. Next state is `OWN_LS_TRAP`.
  - Misaligned fetch is issued with `if_addr[1:0]` forced to 0.
- `MEM_ARB_MISALIGN_TRAP_EN` undefined:
  - No checks are made; all addresses pass through unchanged.
  - `OWN_LS_TRAP` is unreachable and `ls_misaligned` is tied to 0.

## Structure
- `mem_arb_pkg` holds:
  - the `owner_t` enum;
  - the `F3_LB`/`F3_LH`/`F3_LW`/`F3_LBU`/`F3_LHU` and `F3_SB`/`F3_SH`/`F3_SW` localparams;
  - `F3_FETCH = 3'b010`.
- One combinational sub-module, `mem_align_check`, takes `funct3` and `addr[1:0]` and outputs `misaligned`. It is instantiated only under the macro.

## Test plan
- Fetch only, `if_addr` = 0x0, 0x4, 0x8 on consecutive cycles: three `if_rsp_valid` pulses carrying memory words 0, 1, 2 with no bubbles.
- Both ports requesting continuously, `LS_STREAK_MAX` = 4: grant pattern is LS×4, IF×1, repeating.
- SB of 0xA5 to 0x103, then LBU from 0x103: LS response data = 0x000000A5. LB from 0x103 instead returns 0xFFFFFFA5.
- With macro: LW at 0x102 → `ls_rsp_valid` and `ls_misaligned` = 1, data 0, and `mem_write` stays 0. Without macro: the same access returns the word at 0x100.
- Reset asserted in the cycle after a fetch grant: no `if_rsp_valid` is seen. All outputs hold their reset values until the first post-reset request.
